tight_acc_matmul: RTL and testbench

Parametrised N×N matrix-multiply engine on the DCP tightly-coupled accelerator command/response port. It is the successor to the fixed 8×8 accelerator. Matrices A and B are streamed in one element per command, and the product is computed by a sequential multiply-accumulate datapath. Results are read back through a proper valid/ready response handshake. The block has no memory-hierarchy port; operands arrive only through commands.

---
 rtl/tight_acc_pkg.sv | 18 +
 rtl/tight_acc_mac.sv | 13 +
 rtl/tight_acc_matmul.sv | 177 +++++++++++++++++
 tb/tb_tight_acc_matmul.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tight_acc_pkg.sv
// Shared opcodes and controller state encoding for the tightly-coupled
// matrix-multiply accelerator.
package tight_acc_pkg;

  localparam logic [5:0] OP_INIT   = 6'd10;
  localparam logic [5:0] OP_FILLA  = 6'd11;
  localparam logic [5:0] OP_FILLB  = 6'd12;
  localparam logic [5:0] OP_RESULT = 6'd13;
  localparam logic [5:0] OP_STATUS = 6'd15;
  localparam logic [5:0] OP_MULT   = 6'd25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/tight_acc_mac.sv
// Single-stage multiply-add; wraps modulo 2^DW with no saturation.
module tight_acc_mac #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] addend,
  output logic [DW-1:0] sum
);

  assign sum = a * b + addend;

endmodule

// File: rtl/tight_acc_matmul.sv
// N x N matrix-multiply engine: operands streamed in by command, product
// computed one MAC per cycle, results read back over a valid/ready response.
module tight_acc_matmul
  import tight_acc_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_val,
  output logic        busy,
  input  logic [5:0]  cmd_opcode,
  input  logic [63:0] cmd_config_data,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [63:0] resp_data
);

  localparam int CW = $clog2(N);
  localparam int IW = $clog2(N * N);

  state_e state, state_next;

  logic [DW-1:0] a_mem [N*N];
  logic [DW-1:0] b_mem [N*N];
  logic [DW-1:0] r_mem [N*N];

  logic [IW-1:0] fill_a, fill_b, rd_idx;
  logic [CW-1:0] i, j, k;
  logic          accum;
  logic          resp_is_result;
  logic [DW-1:0] acc_p1;
  logic [DW-1:0] mac_a, mac_b, mac_addend, mac_sum, base;
  logic          accept, k_last, mac_last;
  logic          cfg_unused;

  function automatic logic [IW-1:0] idx(input logic [CW-1:0] row,
                                        input logic [CW-1:0] col);
    return IW'(row * N + col);
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(N * N - 1)) ? '0 : v + IW'(1);
  endfunction

  assign busy       = (state != IDLE);
  assign resp_val   = (state == RESP);
  assign accept     = cmd_val && !busy;
  assign cfg_unused = ^cmd_config_data;

  assign k_last   = (k == CW'(N - 1));
  assign mac_last = k_last && (j == CW'(N - 1)) && (i == CW'(N - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_opcode == OP_MULT) state_next = MAC;
          else if (cmd_opcode == OP_RESULT || cmd_opcode == OP_STATUS) state_next = RESP;
        end
      end
      MAC:     if (mac_last) state_next = RESP;
      RESP:    if (resp_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand fetch: one read per array; first term of each dot product seeds from base.
  assign base       = accum ? r_mem[idx(i, j)] : '0;
  assign mac_a      = a_mem[idx(i, k)];
  assign mac_b      = b_mem[idx(k, j)];
  assign mac_addend = (k == '0) ? base : acc_p1;

  tight_acc_mac #(.DW(DW)) u_mac (
    .a      (mac_a),
    .b      (mac_b),
    .addend (mac_addend),
    .sum    (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_a         <= '0;
      fill_b         <= '0;
      rd_idx         <= '0;
      i              <= '0;
      j              <= '0;
      k              <= '0;
      accum          <= 1'b0;
      resp_is_result <= 1'b0;
      resp_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_opcode)
              OP_INIT: begin
                fill_a <= '0;
                fill_b <= '0;
                rd_idx <= '0;
              end
              OP_FILLA: fill_a <= wrap_inc(fill_a);
              OP_FILLB: fill_b <= wrap_inc(fill_b);
              OP_MULT: begin
                accum <= cmd_config_data[0];
                i     <= '0;
                j     <= '0;
                k     <= '0;
              end
              OP_RESULT: begin
                resp_data      <= 64'(r_mem[rd_idx]);
                resp_is_result <= 1'b1;
              end
              OP_STATUS: begin
                resp_data      <= {48'b0, 8'(fill_a), 8'(fill_b)};
                resp_is_result <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MAC: begin
          if (k_last) begin
            k <= '0;
            if (j == CW'(N - 1)) begin
              j <= '0;
              i <= i + CW'(1);
            end else begin
              j <= j + CW'(1);
            end
          end else begin
            k <= k + CW'(1);
          end
          if (mac_last) begin
            resp_data      <= 64'(N * N * N);
            resp_is_result <= 1'b0;
          end
        end
        RESP: begin
          // Read index moves only once the element has actually been taken.
          if (resp_rdy && resp_is_result) rd_idx <= wrap_inc(rd_idx);
        end
        default: ;
      endcase
    end
  end

  // Accumulator stage p1: running dot product, committed to R on the last k.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      case (cmd_opcode)
        OP_INIT: begin
          for (int e = 0; e < N * N; e++) begin
            a_mem[e] <= '0;
            b_mem[e] <= '0;
            r_mem[e] <= '0;
          end
        end
        OP_FILLA: a_mem[fill_a] <= cmd_config_data[DW-1:0];
        OP_FILLB: b_mem[fill_b] <= cmd_config_data[DW-1:0];
        default: ;
      endcase
    end
    if (state == MAC) begin
      acc_p1 <= mac_sum;
      if (k_last) r_mem[idx(i, j)] <= mac_sum;
    end
  end

endmodule

// File: tb/tb_tight_acc_matmul.sv
// Scoreboard bench for tight_acc_matmul across three configurations
// (N=2/DW=64, N=8/DW=64, N=2/DW=8) sharing one command bus.
module tb_tight_acc_matmul;

  localparam logic [5:0] OP_INIT   = 6'd10;
  localparam logic [5:0] OP_FILLA  = 6'd11;
  localparam logic [5:0] OP_FILLB  = 6'd12;
  localparam logic [5:0] OP_RESULT = 6'd13;
  localparam logic [5:0] OP_STATUS = 6'd15;
  localparam logic [5:0] OP_MULT   = 6'd25;

  logic        clk;
  logic [2:0]  rst_v;
  logic        cmd_val;
  logic [5:0]  op;
  logic [63:0] cdata;
  logic        resp_rdy;
  logic [1:0]  sel;

  logic        busy0, busy1, busy2;
  logic        rv0, rv1, rv2;
  logic [63:0] rd0, rd1, rd2;
  logic        busy_s, resp_val_s;
  logic [63:0] resp_data_s;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  tight_acc_matmul #(.N(2), .DW(64)) dut0 (
    .clk(clk), .rst(rst_v[0]), .cmd_val(cmd_val && sel == 2'd0), .busy(busy0),
    .cmd_opcode(op), .cmd_config_data(cdata), .resp_val(rv0),
    .resp_rdy(resp_rdy && sel == 2'd0), .resp_data(rd0));

  tight_acc_matmul #(.N(8), .DW(64)) dut1 (
    .clk(clk), .rst(rst_v[1]), .cmd_val(cmd_val && sel == 2'd1), .busy(busy1),
    .cmd_opcode(op), .cmd_config_data(cdata), .resp_val(rv1),
    .resp_rdy(resp_rdy && sel == 2'd1), .resp_data(rd1));

  tight_acc_matmul #(.N(2), .DW(8)) dut2 (
    .clk(clk), .rst(rst_v[2]), .cmd_val(cmd_val && sel == 2'd2), .busy(busy2),
    .cmd_opcode(op), .cmd_config_data(cdata), .resp_val(rv2),
    .resp_rdy(resp_rdy && sel == 2'd2), .resp_data(rd2));

  always_comb begin
    busy_s      = busy0;
    resp_val_s  = rv0;
    resp_data_s = rd0;
    case (sel)
      2'd1: begin busy_s = busy1; resp_val_s = rv1; resp_data_s = rd1; end
      2'd2: begin busy_s = busy2; resp_val_s = rv2; resp_data_s = rd2; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [5:0] o, input logic [63:0] d);
    op      = o;
    cdata   = d;
    cmd_val = 1'b1;
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  task automatic collect(input string name, input int limit, input int exp_lat);
    int cnt = 0;
    logic [63:0] exp;
    while (!resp_val_s && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (!resp_val_s) begin
      errors++;
      $display("FAIL %s: no resp_val after %0d cycles", name, cnt);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (exp_lat > 0) begin
      checks++;
      if (cnt + 1 !== exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", name, cnt + 1, exp_lat);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected response %0h", name, resp_data_s);
    end else begin
      exp = sb.pop_front();
      if (resp_data_s !== exp) begin
        errors++;
        $display("FAIL %s data: got %0d want %0d", name, resp_data_s, exp);
      end
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    checks++;
    if (busy_s !== 1'b0 || resp_val_s !== 1'b0) begin
      errors++;
      $display("FAIL %s post-transfer: busy=%b resp_val=%b want 0/0", name, busy_s, resp_val_s);
    end
  endtask

  task automatic test_reset;
    rst_v = 3'b111; cmd_val = 1'b0; resp_rdy = 1'b0; sel = 2'd0; op = '0; cdata = '0;
    repeat (3) @(negedge clk);
    rst_v = 3'b000;
    checks++;
    if ({busy0, rv0} !== 2'b00 || rd0 !== 64'd0) begin
      errors++; $display("FAIL reset0: busy=%b val=%b data=%0h want 0", busy0, rv0, rd0);
    end
    checks++;
    if ({busy1, rv1} !== 2'b00 || rd1 !== 64'd0) begin
      errors++; $display("FAIL reset1: busy=%b val=%b data=%0h want 0", busy1, rv1, rd1);
    end
    checks++;
    if ({busy2, rv2} !== 2'b00 || rd2 !== 64'd0) begin
      errors++; $display("FAIL reset2: busy=%b val=%b data=%0h want 0", busy2, rv2, rd2);
    end
  endtask

  task automatic test_init;
    sel = 2'd0;
    issue(OP_INIT, 64'd0);
    for (int n = 0; n < 4; n++) begin
      sb.push_back(64'd0);
      issue(OP_RESULT, 64'd0);
      collect("init_rd", 5, 1);
    end
  endtask

  task automatic test_mult_n2;
    logic [63:0] exp_r [4] = '{64'd19, 64'd22, 64'd43, 64'd50};
    sel = 2'd0;
    for (int n = 0; n < 4; n++) issue(OP_FILLA, 64'(n + 1));
    for (int n = 0; n < 4; n++) issue(OP_FILLB, 64'(n + 5));
    checks++;
    if (busy_s !== 1'b0) begin
      errors++; $display("FAIL fill_busy: busy=%b want 0", busy_s);
    end
    sb.push_back(64'd8);
    issue(OP_MULT, 64'd0);
    checks++;
    if (busy_s !== 1'b1) begin
      errors++; $display("FAIL mult_busy: busy=%b want 1", busy_s);
    end
    collect("mult2", 20, 9);
    for (int n = 0; n < 4; n++) begin
      sb.push_back(exp_r[n]);
      issue(OP_RESULT, 64'd0);
      collect("mult2_rd", 5, 1);
    end
  endtask

  task automatic test_accumulate;
    logic [63:0] exp_r [4] = '{64'd38, 64'd44, 64'd86, 64'd100};
    sel = 2'd0;
    sb.push_back(64'd8);
    issue(OP_MULT, 64'd1);
    collect("acc2", 20, 9);
    for (int n = 0; n < 4; n++) begin
      sb.push_back(exp_r[n]);
      issue(OP_RESULT, 64'd0);
      collect("acc2_rd", 5, 1);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] first;
    sel = 2'd0;
    sb.push_back(64'd38);
    issue(OP_RESULT, 64'd0);
    first   = resp_data_s;
    op      = OP_FILLA;
    cdata   = 64'd99;
    cmd_val = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (resp_val_s !== 1'b1 || resp_data_s !== first || busy_s !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: val=%b data=%0d busy=%b want 1/%0d/1", resp_val_s, resp_data_s, busy_s, first);
      end
    end
    cmd_val = 1'b0;
    collect("bp_rd", 5, 0);
    sb.push_back(64'h0000);
    issue(OP_STATUS, 64'd0);
    collect("bp_status", 5, 1);
    issue(OP_INIT, 64'd0);
    for (int n = 0; n < 3; n++) issue(OP_FILLA, 64'd7);
    sb.push_back(64'h0300);
    issue(OP_STATUS, 64'd0);
    collect("status3", 5, 1);
  endtask

  task automatic test_mult_n8;
    int transfers = 0;
    sel = 2'd1;
    issue(OP_INIT, 64'd0);
    for (int n = 0; n < 64; n++) issue(OP_FILLA, 64'd4);
    for (int n = 0; n < 64; n++) issue(OP_FILLB, 64'd5);
    sb.push_back(64'd512);
    issue(OP_MULT, 64'd0);
    collect("mult8", 600, 513);
    // Back-to-back RESULTs with resp_rdy held high: one element per 2 cycles.
    resp_rdy = 1'b1;
    op       = OP_RESULT;
    cdata    = 64'd0;
    cmd_val  = 1'b1;
    for (int c = 0; c < 128; c++) begin
      if (!busy_s) sb.push_back(64'd160);
      @(negedge clk);
      if (resp_val_s) begin
        transfers++;
        checks++;
        if (sb.size() == 0 || resp_data_s !== sb[0]) begin
          errors++;
          $display("FAIL b2b_rd: got %0d want 160", resp_data_s);
        end
        if (sb.size() > 0) void'(sb.pop_front());
      end
    end
    cmd_val  = 1'b0;
    resp_rdy = 1'b0;
    checks++;
    if (transfers !== 64) begin
      errors++; $display("FAIL b2b_count: got %0d want 64", transfers);
    end
    sb.push_back(64'd160);
    issue(OP_RESULT, 64'd0);
    collect("wrap_rd", 5, 1);
  endtask

  task automatic test_overflow_reset;
    int seen = 0;
    sel = 2'd2;
    issue(OP_INIT, 64'd0);
    for (int n = 0; n < 4; n++) issue(OP_FILLA, 64'd16);
    for (int n = 0; n < 4; n++) issue(OP_FILLB, 64'd16);
    sb.push_back(64'd8);
    issue(OP_MULT, 64'd0);
    collect("ovf_mult", 20, 9);
    for (int n = 0; n < 4; n++) begin
      sb.push_back(64'd0);
      issue(OP_RESULT, 64'd0);
      collect("ovf16_rd", 5, 1);
    end
    for (int n = 0; n < 4; n++) issue(OP_FILLA, 64'd12);
    for (int n = 0; n < 4; n++) issue(OP_FILLB, 64'd12);
    sb.push_back(64'd8);
    issue(OP_MULT, 64'd0);
    collect("ovf_mult12", 20, 9);
    for (int n = 0; n < 4; n++) begin
      sb.push_back(64'd32);
      issue(OP_RESULT, 64'd0);
      collect("ovf12_rd", 5, 1);
    end
    issue(OP_MULT, 64'd0);
    repeat (2) @(negedge clk);
    rst_v[2] = 1'b1;
    @(negedge clk);
    rst_v[2] = 1'b0;
    checks++;
    if (busy_s !== 1'b0 || resp_val_s !== 1'b0) begin
      errors++; $display("FAIL rst_mac: busy=%b val=%b want 0/0", busy_s, resp_val_s);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_val_s) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_noresp: resp_val high %0d cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_mult_n2();
    test_accumulate();
    test_backpressure();
    test_mult_n8();
    test_overflow_reset();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
